l2_cache_ctrl: RTL and testbench
================================

Name: l2_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L2 cache controller between the L1 request port (addr/we/data/stall) and main memory.
- Holds the tag, valid, dirty and data arrays internally.
- Sequences lookup, dirty-line writeback and line fill as multi-beat bursts over a req/ack memory port.
- Signals completion to L1 by dropping `stall`; keeps hit, miss and writeback counters.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width on both ports.
- INDEX_W, 6, line index bits (64 lines).
- OFF_W, 2, word-offset bits (4 words/line = LINE_WORDS).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- l1_req  in  1  request valid; L1 holds it and addr/we/wdata stable until l1_done.
- l1_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- l1_we  in  1  1 = write, 0 = read.
- l1_wdata  in  DATA_W  write data.
- l1_rdata  out  DATA_W  read data, valid while l1_done=1.
- stall  out  1  controller busy with the accepted request.
- l1_done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory beat request, held until mem_ack.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  fill data, valid with mem_ack.
- mem_ack  in  1  beat complete this cycle.
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W  statistics, wrap at 2^CNT_W.

Behaviour:
- Address split: word = addr[OFF_W+1:2]; index = next INDEX_W bits; tag = remaining upper bits.
- Reset (async) clears:
  - all valid and dirty bits; state=IDLE;
  - stall, l1_done, mem_req, mem_we = 0;
  - mem_addr, mem_wdata, l1_rdata = 0;
  - beat counter and all statistics counters = 0.
- Tag/data arrays are not reset.
- All outputs are registered.
- States:
  - IDLE: stall=0. If l1_req=1, latch addr/we/wdata and go to LOOKUP.
  - LOOKUP: stall=1. Three cases:
    - hit (valid && tag match): hit_cnt++, go to RESP.
    - miss with dirty victim: miss_cnt++, go to WB, beat=0.
    - miss with clean or invalid victim: miss_cnt++, go to FILL, beat=0.
  - WB: stall=1.
    - mem_req=1, mem_we=1, mem_addr={victim tag, index, beat, 2'b00}, mem_wdata=data[index][beat].
    - On mem_ack: beat++ and the next beat is presented the following cycle.
    - On the ack of beat LINE_WORDS-1: clear dirty, wb_cnt++, go to FILL with beat=0.
  - FILL: stall=1.
    - mem_req=1, mem_we=0, mem_addr={new tag, index, beat, 2'b00}.
    - On mem_ack: write mem_rdata into data[index][beat].
    - On the last ack: set valid and write the tag, dirty=0, go to LOOKUP. The re-lookup now hits but is not counted as a hit (one flag suppresses it).
  - RESP: stall=0, l1_done=1.
    - Read: l1_rdata = data[index][word].
    - Write: data[index][word] = wdata, dirty=1; l1_rdata = wdata.
    - Go to IDLE. l1_req is ignored in RESP.
- Latency, req sampled at cycle 0:
  - hit: l1_done at cycle 2;
  - clean miss: 2 + 4 fill beats + 1 re-lookup;
  - dirty miss adds 4 writeback beats.
- mem_req stays high across back-to-back beats. mem_ack with mem_req=0 is ignored.
- Fill writes valid and tag only on the final beat, so a partial fill is never visible.
- Reset mid-burst: mem_req drops immediately and the line is left invalid. The dirty bit of a partially written-back victim is cleared by reset; data loss on reset is accepted.
- Back-to-back requests: a minimum of one IDLE cycle between l1_done and the next acceptance.

Decomposition:
- Package l2_cache_pkg:
  - state enum {IDLE, LOOKUP, WB, FILL, RESP};
  - derived widths TAG_W = ADDR_W-INDEX_W-OFF_W-2 and LINE_WORDS = 1<<OFF_W;
  - address-field slicing functions.
- Sub-module l2_tag_store: tag array, valid/dirty flops, and hit compare. Ports: index, tag, set_valid, set_dirty, clr_dirty → hit, victim_tag, victim_dirty.

Test Plan:
- Reset then read 0x0000_0040, memory returns 0xA0..0xA3 with ack each cycle → miss_cnt=1, l1_rdata=0xA0 (word 0), l1_done 7 cycles after req.
- Repeat read 0x0000_0044 → hit_cnt=1, l1_rdata=0xA1, l1_done exactly 2 cycles after req, no mem_req.
- Write 0xDEADBEEF to 0x0000_0048 (hit), then read 0x0000_1048 (same index, new tag) → 4 WB beats to 0x40..0x4C, third beat data 0xDEADBEEF, wb_cnt=1, then 4 fill beats from 0x1040.
- Memory ack delayed 3 cycles per beat → mem_req and mem_addr stable through each wait, beat advances only on ack.
- Assert reset during fill beat 2 → mem_req=0 and stall=0 the same cycle. A following read of the same line misses again (miss_cnt=1 after the post-reset request).
- Write miss to 0x0000_0100 with data 0x12345678 → fill, then RESP sets dirty. A later conflicting read writes back 0x12345678 at 0x100.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared types, derived widths and address-field helpers for the L2 cache controller.
package l2_cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned INDEX_W    = 6;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int unsigned LINE_WORDS = 1 << OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_e;

  function automatic logic [OFF_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFF_W+1:2];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFF_W+2 +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/l2_tag_store.sv
// Tag array plus valid/dirty flags for a direct-mapped cache; combinational hit/victim lookup.
module l2_tag_store #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_set_valid,
  input  logic               i_set_dirty,
  input  logic               i_clr_dirty,
  output logic               o_hit_c,
  output logic [TAG_W-1:0]   o_victim_tag_c,
  output logic               o_victim_dirty_c
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] r_tag [LINES];
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;

  // Tags are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (i_set_valid) r_tag[i_index] <= i_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_set_valid) r_valid[i_index] <= 1'b1;
      if (i_set_dirty)      r_dirty[i_index] <= 1'b1;
      else if (i_clr_dirty) r_dirty[i_index] <= 1'b0;
    end
  end

  assign o_hit_c          = r_valid[i_index] && (r_tag[i_index] == i_tag);
  assign o_victim_tag_c   = r_tag[i_index];
  assign o_victim_dirty_c = r_valid[i_index] && r_dirty[i_index];

endmodule

// File: rtl/l2_cache_ctrl.sv
// Direct-mapped write-back/write-allocate L2 controller: lookup, dirty writeback and
// line fill sequenced as 4-beat bursts over a req/ack memory port.
module l2_cache_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned OFF_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l1_req,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic              l1_we,
  input  logic [DATA_W-1:0] l1_wdata,
  output logic [DATA_W-1:0] l1_rdata,
  output logic              stall,
  output logic              l1_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);
  import l2_cache_pkg::*;

  localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int unsigned LINE_WORDS = 1 << OFF_W;
  localparam int unsigned WORDS      = (1 << INDEX_W) * LINE_WORDS;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e r_state, w_state;
  logic [ADDR_W-3:0] r_waddr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [OFF_W-1:0]  r_beat, w_beat, w_beat_nxt;
  logic              r_refill, w_refill;
  logic              r_stall, w_stall, r_done, w_done;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic              r_mreq, w_mreq, r_mwe, w_mwe;
  logic [ADDR_W-1:0] r_maddr, w_maddr;
  logic [DATA_W-1:0] r_mwdata, w_mwdata;
  logic [CNT_W-1:0]  r_hit_cnt, w_hit_cnt, r_miss_cnt, w_miss_cnt, r_wb_cnt, w_wb_cnt;
  logic [DATA_W-1:0] r_data [WORDS];

  logic                      w_accept, w_ack, w_hit, w_victim_dirty;
  logic                      w_set_valid, w_set_dirty, w_clr_dirty;
  logic                      w_dwe;
  logic [INDEX_W+OFF_W-1:0]  w_dwaddr;
  logic [DATA_W-1:0]         w_dwdata;
  logic [TAG_W-1:0]          w_tag, w_victim_tag;
  logic [INDEX_W-1:0]        w_index;
  logic [OFF_W-1:0]          w_word;
  logic                      w_unused;

  assign w_unused   = &{1'b0, l1_addr[1:0]};
  assign w_word     = r_waddr[OFF_W-1:0];
  assign w_index    = r_waddr[OFF_W +: INDEX_W];
  assign w_tag      = r_waddr[ADDR_W-3 -: TAG_W];
  assign w_ack      = mem_ack && r_mreq;
  assign w_beat_nxt = r_beat + OFF_W'(1);

  l2_tag_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
    .clk              (clk),
    .reset            (reset),
    .i_index          (w_index),
    .i_tag            (w_tag),
    .i_set_valid      (w_set_valid),
    .i_set_dirty      (w_set_dirty),
    .i_clr_dirty      (w_clr_dirty),
    .o_hit_c          (w_hit),
    .o_victim_tag_c   (w_victim_tag),
    .o_victim_dirty_c (w_victim_dirty)
  );

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    w_state     = r_state;
    w_beat      = r_beat;
    w_refill    = r_refill;
    w_stall     = r_stall;
    w_done      = 1'b0;
    w_rdata     = r_rdata;
    w_mreq      = r_mreq;
    w_mwe       = r_mwe;
    w_maddr     = r_maddr;
    w_mwdata    = r_mwdata;
    w_hit_cnt   = r_hit_cnt;
    w_miss_cnt  = r_miss_cnt;
    w_wb_cnt    = r_wb_cnt;
    w_accept    = 1'b0;
    w_set_valid = 1'b0;
    w_set_dirty = 1'b0;
    w_clr_dirty = 1'b0;
    w_dwe       = 1'b0;
    w_dwaddr    = {w_index, r_beat};
    w_dwdata    = mem_rdata;
    case (r_state)
      IDLE: begin
        // The request still held in the cycle after l1_done belongs to the finished access.
        if (l1_req && !r_done) begin
          w_accept = 1'b1;
          w_stall  = 1'b1;
          w_state  = LOOKUP;
        end
      end
      LOOKUP: begin
        w_beat = '0;
        if (w_hit) begin
          if (!r_refill) w_hit_cnt = r_hit_cnt + CNT_W'(1);
          w_refill = 1'b0;
          w_state  = RESP;
        end else begin
          w_miss_cnt = r_miss_cnt + CNT_W'(1);
          w_mreq     = 1'b1;
          if (w_victim_dirty) begin
            w_mwe    = 1'b1;
            w_maddr  = {w_victim_tag, w_index, OFF_W'(0), 2'b00};
            w_mwdata = r_data[{w_index, OFF_W'(0)}];
            w_state  = WB;
          end else begin
            w_mwe   = 1'b0;
            w_maddr = {w_tag, w_index, OFF_W'(0), 2'b00};
            w_state = FILL;
          end
        end
      end
      WB: begin
        if (w_ack) begin
          if (r_beat == LAST_BEAT) begin
            w_clr_dirty = 1'b1;
            w_wb_cnt    = r_wb_cnt + CNT_W'(1);
            w_beat      = '0;
            w_mwe       = 1'b0;
            w_maddr     = {w_tag, w_index, OFF_W'(0), 2'b00};
            w_state     = FILL;
          end else begin
            w_beat   = w_beat_nxt;
            w_maddr  = {w_victim_tag, w_index, w_beat_nxt, 2'b00};
            w_mwdata = r_data[{w_index, w_beat_nxt}];
          end
        end
      end
      FILL: begin
        if (w_ack) begin
          w_dwe = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_set_valid = 1'b1;
            w_clr_dirty = 1'b1;
            w_refill    = 1'b1;
            w_mreq      = 1'b0;
            w_beat      = '0;
            w_state     = LOOKUP;
          end else begin
            w_beat  = w_beat_nxt;
            w_maddr = {w_tag, w_index, w_beat_nxt, 2'b00};
          end
        end
      end
      RESP: begin
        w_stall = 1'b0;
        w_done  = 1'b1;
        w_state = IDLE;
        if (r_we) begin
          w_dwe       = 1'b1;
          w_dwaddr    = {w_index, w_word};
          w_dwdata    = r_wdata;
          w_set_dirty = 1'b1;
          w_rdata     = r_wdata;
        end else begin
          w_rdata = r_data[{w_index, w_word}];
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_waddr    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_beat     <= '0;
      r_refill   <= 1'b0;
      r_stall    <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_mreq     <= 1'b0;
      r_mwe      <= 1'b0;
      r_maddr    <= '0;
      r_mwdata   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      r_state    <= w_state;
      r_beat     <= w_beat;
      r_refill   <= w_refill;
      r_stall    <= w_stall;
      r_done     <= w_done;
      r_rdata    <= w_rdata;
      r_mreq     <= w_mreq;
      r_mwe      <= w_mwe;
      r_maddr    <= w_maddr;
      r_mwdata   <= w_mwdata;
      r_hit_cnt  <= w_hit_cnt;
      r_miss_cnt <= w_miss_cnt;
      r_wb_cnt   <= w_wb_cnt;
      if (w_accept) begin
        r_waddr <= l1_addr[ADDR_W-1:2];
        r_we    <= l1_we;
        r_wdata <= l1_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_dwe) r_data[w_dwaddr] <= w_dwdata;
  end

  assign l1_rdata  = r_rdata;
  assign stall     = r_stall;
  assign l1_done   = r_done;
  assign mem_req   = r_mreq;
  assign mem_we    = r_mwe;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_mwdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign wb_cnt    = r_wb_cnt;

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Scoreboard bench for l2_cache_ctrl: expected L1 responses and memory beats are queued
// by the stimulus; a monitor and a memory responder pop and compare them.
module tb_l2_cache_ctrl;
  import l2_cache_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              l1_req;
  logic [ADDR_W-1:0] l1_addr;
  logic              l1_we;
  logic [DATA_W-1:0] l1_wdata;
  logic [DATA_W-1:0] l1_rdata;
  logic              stall;
  logic              l1_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt, wb_cnt;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          hits;
    int          misses;
    int          wbs;
  } resp_t;

  beat_t       exp_beats[$];
  resp_t       exp_resp[$];
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  int          ack_delay = 0;

  l2_cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .l1_req    (l1_req),
    .l1_addr   (l1_addr),
    .l1_we     (l1_we),
    .l1_wdata  (l1_wdata),
    .l1_rdata  (l1_rdata),
    .stall     (stall),
    .l1_done   (l1_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic we, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.we = we; b.addr = a; b.data = d;
    exp_beats.push_back(b);
  endtask

  task automatic push_fill(input logic [31:0] a);
    logic [31:0] base;
    base = {addr_tag(a), addr_index(a), OFF_W'(0), 2'b00};
    for (int i = 0; i < int'(LINE_WORDS); i++) push_beat(1'b0, base + 32'(4 * i), 32'h0);
  endtask

  task automatic push_wb(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    push_beat(1'b1, base,          d0);
    push_beat(1'b1, base + 32'h4,  d1);
    push_beat(1'b1, base + 32'h8,  d2);
    push_beat(1'b1, base + 32'hC,  d3);
  endtask

  // Queue the expected response, present the request and hold it until l1_done.
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd, input int lat,
                       input logic [31:0] rd, input int h, input int m, input int w);
    resp_t r;
    bit    seen;
    r.rdata = rd; r.lat = lat; r.hits = h; r.misses = m; r.wbs = w;
    exp_resp.push_back(r);
    @(negedge clk);
    l1_addr = a; l1_we = we; l1_wdata = wd; l1_req = 1'b1;
    req_cyc = cyc + 1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (l1_done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: no l1_done for addr 0x%08h", a);
    end
    l1_req = 1'b0;
  endtask

  // Monitor: every l1_done pops one expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (l1_done) begin
        if (exp_resp.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: rdata 0x%08h with nothing expected", l1_rdata);
        end else begin
          r = exp_resp.pop_front();
          chk("rdata",         l1_rdata,             r.rdata);
          chk("latency",       32'(cyc - req_cyc),   32'(r.lat));
          chk("hit_cnt",       32'(hit_cnt),         32'(r.hits));
          chk("miss_cnt",      32'(miss_cnt),        32'(r.misses));
          chk("wb_cnt",        32'(wb_cnt),          32'(r.wbs));
          chk("stall_at_done", 32'(stall),           32'h0);
        end
      end
    end
  end

  // Memory responder: acks each beat after ack_delay wait cycles, checking it holds steady.
  initial begin
    int          wait_cnt;
    logic [31:0] seen_addr;
    beat_t       b;
    wait_cnt = 0;
    seen_addr = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req || reset) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) seen_addr = mem_addr;
        else chk("beat_addr_stable", mem_addr, seen_addr);
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          if (exp_beats.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_beat: we=%0b addr 0x%08h", mem_we, mem_addr);
            mem_rdata = '0;
          end else begin
            b = exp_beats.pop_front();
            chk("beat_we",   32'(mem_we), 32'(b.we));
            chk("beat_addr", mem_addr,    b.addr);
            if (b.we) chk("beat_wdata", mem_wdata, b.data);
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
          mem_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1; l1_req = 1'b0; l1_addr = '0; l1_we = 1'b0; l1_wdata = '0;
    mem[32'h40] = 32'hA0; mem[32'h44] = 32'hA1; mem[32'h48] = 32'hA2; mem[32'h4C] = 32'hA3;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall",    32'(stall),    32'h0);
    chk("rst_done",     32'(l1_done),  32'h0);
    chk("rst_mem_req",  32'(mem_req),  32'h0);
    chk("rst_mem_we",   32'(mem_we),   32'h0);
    chk("rst_mem_addr", mem_addr,      32'h0);
    chk("rst_mem_wd",   mem_wdata,     32'h0);
    chk("rst_rdata",    l1_rdata,      32'h0);
    chk("rst_hits",     32'(hit_cnt),  32'h0);
    chk("rst_misses",   32'(miss_cnt), 32'h0);
    chk("rst_wbs",      32'(wb_cnt),   32'h0);

    // Clean miss, then hits on the same line (read word 1, write word 2)
    push_fill(32'h40);
    issue(32'h40, 1'b0, 32'h0, 7, 32'hA0, 0, 1, 0);
    issue(32'h44, 1'b0, 32'h0, 2, 32'hA1, 1, 1, 0);
    issue(32'h48, 1'b1, 32'hDEADBEEF, 2, 32'hDEADBEEF, 2, 1, 0);

    // Conflict on index 4 evicts the dirty line
    push_wb(32'h40, 32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3);
    push_fill(32'h1048);
    issue(32'h1048, 1'b0, 32'h0, 11, 32'hC000_1048, 2, 2, 1);

    // Slow memory: 3 wait cycles per beat
    ack_delay = 3;
    push_fill(32'h304);
    issue(32'h304, 1'b0, 32'h0, 19, 32'hC000_0304, 2, 3, 1);
    issue(32'h308, 1'b0, 32'h0, 2, 32'hC000_0308, 3, 3, 1);

    // Reset while fill beat 2 is outstanding
    push_fill(32'h200);
    @(negedge clk);
    l1_addr = 32'h200; l1_we = 1'b0; l1_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h208) found = 1'b1;
    end
    chk("rst_trigger_seen", 32'(found), 32'h1);
    #1;
    reset = 1'b1;
    l1_req = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req),  32'h0);
    chk("midrst_stall",   32'(stall),    32'h0);
    chk("midrst_misses",  32'(miss_cnt), 32'h0);
    exp_beats.delete();
    @(negedge clk);
    reset = 1'b0;
    ack_delay = 0;
    push_fill(32'h200);
    issue(32'h200, 1'b0, 32'h0, 7, 32'hC000_0200, 0, 1, 0);

    // Write miss allocates and dirties; conflicting read writes it back
    push_fill(32'h100);
    issue(32'h100, 1'b1, 32'h12345678, 7, 32'h12345678, 0, 2, 0);
    push_wb(32'h100, 32'h12345678, 32'hC000_0104, 32'hC000_0108, 32'hC000_010C);
    push_fill(32'h2100);
    issue(32'h2100, 1'b0, 32'h0, 11, 32'hC000_2100, 0, 3, 1);
    issue(32'h210C, 1'b0, 32'h0, 2, 32'hC000_210C, 1, 3, 1);

    repeat (3) @(negedge clk);
    chk("beats_left", 32'(exp_beats.size()), 32'h0);
    chk("resp_left",  32'(exp_resp.size()),  32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
